// File: rtl/hazard_ctrl_if.sv
// D-stage request / hazard-decision bundle between the decode stage and hazard_ctrl.
// Optional statistics ports exist only when HAZARD_STAT_EN is defined.
interface hazard_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic [4:0]  d_wa;
  logic        d_we;
  logic [1:0]  d_tnew;
  logic        d_md_start;
  logic        d_md_div;
  logic        d_md_use;
  logic        stall;
  logic [1:0]  fwd_d_rs;
  logic [1:0]  fwd_d_rt;
  logic [1:0]  fwd_e_rs;
  logic [1:0]  fwd_e_rt;
  logic        md_busy;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy,
           stall_cnt, md_stall_cnt
  );
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy,
           stall_cnt, md_stall_cnt
  );
`else
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );
  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: Tuse/Tnew stall, M/W forwarding, MDU busy window.
// Define HAZARD_STAT_EN to add the stall_cnt / md_stall_cnt statistics counters.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  // E stage
  logic [4:0]       e_wa_q, e_wa_d;
  logic             e_we_q, e_we_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic [4:0]       e_rs_q, e_rs_d;
  logic [4:0]       e_rt_q, e_rt_d;
  logic             e_md_start_q, e_md_start_d;
  logic             e_md_div_q, e_md_div_d;
  // M stage
  logic [4:0]       m_wa_q, m_wa_d;
  logic             m_we_q, m_we_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  // W stage
  logic [4:0]       w_wa_q, w_wa_d;
  logic             w_we_q, w_we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_reg, stall_md;

  function automatic logic hit(input logic we, input logic [4:0] wa, input logic [4:0] r);
    return we && (wa == r) && (r != 5'd0);
  endfunction

  function automatic logic late(input logic [1:0] tuse, input logic [1:0] tnew);
    return (tuse != 2'd3) && (tuse < tnew);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic m_we, input logic [4:0] m_wa,
                                         input logic [1:0] m_tnew,
                                         input logic w_we, input logic [4:0] w_wa);
    if (hit(m_we, m_wa, r) && (m_tnew == 2'd0)) return 2'b01;
    else if (hit(w_we, w_wa, r))                return 2'b10;
    else                                        return 2'b00;
  endfunction

  always_comb begin
    stall_reg = (hit(e_we_q, e_wa_q, hz.d_rs) && late(hz.d_tuse_rs, e_tnew_q)) ||
                (hit(e_we_q, e_wa_q, hz.d_rt) && late(hz.d_tuse_rt, e_tnew_q)) ||
                (hit(m_we_q, m_wa_q, hz.d_rs) && late(hz.d_tuse_rs, m_tnew_q)) ||
                (hit(m_we_q, m_wa_q, hz.d_rt) && late(hz.d_tuse_rt, m_tnew_q));
    stall_md  = hz.d_md_use && ((cnt_q != '0) || e_md_start_q);
  end

  assign hz.stall    = stall_reg || stall_md;
  assign hz.md_busy  = (cnt_q != '0);
  assign hz.fwd_d_rs = fwd_sel(hz.d_rs, m_we_q, m_wa_q, m_tnew_q, w_we_q, w_wa_q);
  assign hz.fwd_d_rt = fwd_sel(hz.d_rt, m_we_q, m_wa_q, m_tnew_q, w_we_q, w_wa_q);
  assign hz.fwd_e_rs = fwd_sel(e_rs_q, m_we_q, m_wa_q, m_tnew_q, w_we_q, w_wa_q);
  assign hz.fwd_e_rt = fwd_sel(e_rt_q, m_we_q, m_wa_q, m_tnew_q, w_we_q, w_wa_q);

  // A stalled D instruction stays put; E receives an all-zero bubble instead.
  always_comb begin
    e_wa_d       = hz.stall ? 5'd0 : hz.d_wa;
    e_we_d       = hz.stall ? 1'b0 : hz.d_we;
    e_tnew_d     = hz.stall ? 2'd0 : hz.d_tnew;
    e_rs_d       = hz.stall ? 5'd0 : hz.d_rs;
    e_rt_d       = hz.stall ? 5'd0 : hz.d_rt;
    e_md_start_d = hz.stall ? 1'b0 : hz.d_md_start;
    e_md_div_d   = hz.stall ? 1'b0 : hz.d_md_div;
    m_wa_d       = e_wa_q;
    m_we_d       = e_we_q;
    m_tnew_d     = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    w_wa_d       = m_wa_q;
    w_we_d       = m_we_q;
    if (e_md_start_q)
      cnt_d = e_md_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
    else
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_wa_q       <= '0;
      e_we_q       <= 1'b0;
      e_tnew_q     <= '0;
      e_rs_q       <= '0;
      e_rt_q       <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      m_wa_q       <= '0;
      m_we_q       <= 1'b0;
      m_tnew_q     <= '0;
      w_wa_q       <= '0;
      w_we_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      e_wa_q       <= e_wa_d;
      e_we_q       <= e_we_d;
      e_tnew_q     <= e_tnew_d;
      e_rs_q       <= e_rs_d;
      e_rt_q       <= e_rt_d;
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
      m_wa_q       <= m_wa_d;
      m_we_q       <= m_we_d;
      m_tnew_q     <= m_tnew_d;
      w_wa_q       <= w_wa_d;
      w_we_q       <= w_we_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = hz.stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    md_stall_cnt_d = stall_md ? md_stall_cnt_q + 32'd1 : md_stall_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: pipeline-occupancy model plus hand-computed scenario checks.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic [4:0] wa;
    logic       we;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mds;
    logic       mdd;
  } instr_t;

  logic   clk;
  logic   reset;
  logic   run;
  instr_t d_cur;
  logic [1:0] tu_rs, tu_rt;
  logic   md_use;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_if hzif ();

  assign hzif.d_rs       = d_cur.rs;
  assign hzif.d_rt       = d_cur.rt;
  assign hzif.d_wa       = d_cur.wa;
  assign hzif.d_we       = d_cur.we;
  assign hzif.d_tnew     = d_cur.tnew;
  assign hzif.d_md_start = d_cur.mds;
  assign hzif.d_md_div   = d_cur.mdd;
  assign hzif.d_tuse_rs  = tu_rs;
  assign hzif.d_tuse_rt  = tu_rt;
  assign hzif.d_md_use   = md_use;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hzif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pipe[0]=E, pipe[1]=M, pipe[2]=W hold whole instructions; MDU is a busy-until cycle.
  instr_t pipe [3];
  longint cyc;
  longint busy_end;
  bit     busy_v;

  function automatic int tnew_rem(input instr_t x, input int age);
    int t;
    t = int'(x.tnew) - age;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_match(input instr_t x, input logic [4:0] r);
    return x.we && (x.wa == r) && (r != 5'd0);
  endfunction

  function automatic bit m_busy();
    return busy_v && (cyc <= busy_end);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (tu_rs != 2'd3 && m_match(pipe[k], d_cur.rs) && int'(tu_rs) < tnew_rem(pipe[k], k)) s = 1'b1;
      if (tu_rt != 2'd3 && m_match(pipe[k], d_cur.rt) && int'(tu_rt) < tnew_rem(pipe[k], k)) s = 1'b1;
    end
    if (md_use && (m_busy() || pipe[0].mds)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (m_match(pipe[1], r) && tnew_rem(pipe[1], 1) == 0) return 2'b01;
    if (m_match(pipe[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      cyc = 0; busy_v = 1'b0; busy_end = 0;
    end else begin
      bit s;
      s = m_stall();
      if (pipe[0].mds) begin
        busy_v   = 1'b1;
        busy_end = cyc + (pipe[0].mdd ? DIV_N : MULT_N);
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = s ? instr_t'('0) : d_cur;
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run && !reset) begin
      bit s;
      s = m_stall();
      chk("stall", 32'(hzif.stall), 32'(s));
      chk("md_busy", 32'(hzif.md_busy), 32'(m_busy()));
      chk("fwd_e_rs", 32'(hzif.fwd_e_rs), 32'(m_fwd(pipe[0].rs)));
      chk("fwd_e_rt", 32'(hzif.fwd_e_rt), 32'(m_fwd(pipe[0].rt)));
      if (!s) begin
        chk("fwd_d_rs", 32'(hzif.fwd_d_rs), 32'(m_fwd(d_cur.rs)));
        chk("fwd_d_rt", 32'(hzif.fwd_d_rt), 32'(m_fwd(d_cur.rt)));
      end
    end
  end

  function automatic instr_t mk(input int wa, input bit we, input int tnew,
                                input int rs, input int rt, input bit mds, input bit mdd);
    instr_t x;
    x.wa = 5'(wa); x.we = we; x.tnew = 2'(tnew);
    x.rs = 5'(rs); x.rt = 5'(rt); x.mds = mds; x.mdd = mdd;
    return x;
  endfunction

  // Presents an instruction in D until it is accepted; returns stall count and D selects at acceptance.
  task automatic issue(input instr_t ins, input logic [1:0] trs, input logic [1:0] trt,
                       input logic use_md, output int nst,
                       output logic [1:0] frs, output logic [1:0] frt);
    bit s, done;
    d_cur = ins; tu_rs = trs; tu_rt = trt; md_use = use_md;
    nst = 0; done = 1'b0; frs = 2'b00; frt = 2'b00;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      s = hzif.stall; frs = hzif.fwd_d_rs; frt = hzif.fwd_d_rt;
      @(posedge clk); #1;
      if (!s) done = 1'b1;
      else nst++;
    end
    if (!done) chk("issue_timeout", 32'(nst), 32'd0);
  endtask

  task automatic nops(input int n);
    int ns; logic [1:0] a, b;
    for (int i = 0; i < n; i++) issue('0, 2'd3, 2'd3, 1'b0, ns, a, b);
  endtask

  int ns;
  logic [1:0] frs, frt;

  initial begin
    run = 1'b0; reset = 1'b1;
    d_cur = '0; tu_rs = 2'd3; tu_rt = 2'd3; md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(hzif.stall), 32'd0);
    chk("rst_fwd_d", {30'd0, hzif.fwd_d_rs} | {30'd0, hzif.fwd_d_rt}, 32'd0);
    chk("rst_fwd_e", {30'd0, hzif.fwd_e_rs} | {30'd0, hzif.fwd_e_rt}, 32'd0);
    chk("rst_md_busy", 32'(hzif.md_busy), 32'd0);
    @(negedge clk); #1 reset = 1'b0; run = 1'b1;

    // lw $1 ; add $2,$1,$3
    issue(mk(1, 1, 2, 0, 0, 0, 0), 2'd1, 2'd3, 1'b0, ns, frs, frt);
    issue(mk(2, 1, 1, 1, 3, 0, 0), 2'd1, 2'd1, 1'b0, ns, frs, frt);
    chk("lw_add_stalls", 32'(ns), 32'd1);
    chk("lw_add_fwd_e_rs", 32'(hzif.fwd_e_rs), 32'b10);
    nops(3);

    // add $1 ; beq $1,$1
    issue(mk(1, 1, 1, 2, 3, 0, 0), 2'd1, 2'd1, 1'b0, ns, frs, frt);
    issue(mk(0, 0, 0, 1, 1, 0, 0), 2'd0, 2'd0, 1'b0, ns, frs, frt);
    chk("add_beq_stalls", 32'(ns), 32'd1);
    chk("add_beq_fwd_d_rs", 32'(frs), 32'b01);
    chk("add_beq_fwd_d_rt", 32'(frt), 32'b01);
    nops(3);

    // add $4 ; sw $4,0($5)
    issue(mk(4, 1, 1, 0, 0, 0, 0), 2'd1, 2'd1, 1'b0, ns, frs, frt);
    issue(mk(0, 0, 0, 5, 4, 0, 0), 2'd1, 2'd2, 1'b0, ns, frs, frt);
    chk("add_sw_stalls", 32'(ns), 32'd0);
    chk("add_sw_fwd_e_rt", 32'(hzif.fwd_e_rt), 32'b01);
    nops(3);

    // write $0 ; branch reading $0
    issue(mk(0, 1, 2, 0, 0, 0, 0), 2'd1, 2'd1, 1'b0, ns, frs, frt);
    issue(mk(0, 0, 0, 0, 0, 0, 0), 2'd0, 2'd0, 1'b0, ns, frs, frt);
    chk("r0_stalls", 32'(ns), 32'd0);
    chk("r0_fwd_d", {30'd0, frs} | {30'd0, frt}, 32'd0);
    chk("r0_fwd_e", {30'd0, hzif.fwd_e_rs} | {30'd0, hzif.fwd_e_rt}, 32'd0);
    nops(3);

    // M beats W: add $5 ; add $5 ; beq $5,$5
    issue(mk(5, 1, 1, 0, 0, 0, 0), 2'd1, 2'd1, 1'b0, ns, frs, frt);
    issue(mk(5, 1, 1, 0, 0, 0, 0), 2'd1, 2'd1, 1'b0, ns, frs, frt);
    issue(mk(0, 0, 0, 5, 5, 0, 0), 2'd0, 2'd0, 1'b0, ns, frs, frt);
    chk("mw_prio_stalls", 32'(ns), 32'd1);
    chk("mw_prio_fwd_d_rs", 32'(frs), 32'b01);
    nops(3);

    // W-only D forward: lw $6 ; nop ; nop ; beq $6
    issue(mk(6, 1, 2, 0, 0, 0, 0), 2'd1, 2'd3, 1'b0, ns, frs, frt);
    nops(2);
    issue(mk(0, 0, 0, 6, 0, 0, 0), 2'd0, 2'd0, 1'b0, ns, frs, frt);
    chk("w_fwd_stalls", 32'(ns), 32'd0);
    chk("w_fwd_d_rs", 32'(frs), 32'b10);
    nops(3);

    // div ; mflo  (1 cycle div in E + 10 busy cycles)
    issue(mk(0, 0, 0, 7, 8, 1, 1), 2'd1, 2'd1, 1'b1, ns, frs, frt);
    issue(mk(3, 1, 1, 0, 0, 0, 0), 2'd3, 2'd3, 1'b1, ns, frs, frt);
    chk("div_mflo_stalls", 32'(ns), 32'd11);
    chk("div_done_busy", 32'(hzif.md_busy), 32'd0);
    nops(2);

    // mult ; mflo
    issue(mk(0, 0, 0, 7, 8, 1, 0), 2'd1, 2'd1, 1'b1, ns, frs, frt);
    issue(mk(3, 1, 1, 0, 0, 0, 0), 2'd3, 2'd3, 1'b1, ns, frs, frt);
    chk("mult_mflo_stalls", 32'(ns), 32'd6);
    nops(3);

    // reset mid-div (counter at 6) with lw $9 in E and a dependent add in D
    issue(mk(0, 0, 0, 7, 8, 1, 1), 2'd1, 2'd1, 1'b1, ns, frs, frt);
    nops(4);
    issue(mk(9, 1, 2, 0, 0, 0, 0), 2'd1, 2'd3, 1'b0, ns, frs, frt);
    d_cur = mk(10, 1, 1, 9, 0, 0, 0); tu_rs = 2'd1; tu_rt = 2'd3; md_use = 1'b0;
    #1;
    chk("pre_rst_md_busy", 32'(hzif.md_busy), 32'd1);
    chk("pre_rst_stall", 32'(hzif.stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_stall", 32'(hzif.stall), 32'd0);
    chk("async_rst_md_busy", 32'(hzif.md_busy), 32'd0);
    chk("async_rst_fwd_d", {30'd0, hzif.fwd_d_rs} | {30'd0, hzif.fwd_d_rt}, 32'd0);
    chk("async_rst_fwd_e", {30'd0, hzif.fwd_e_rs} | {30'd0, hzif.fwd_e_rt}, 32'd0);
`ifdef HAZARD_STAT_EN
    chk("async_rst_stall_cnt", hzif.stall_cnt, 32'd0);
    chk("async_rst_md_stall_cnt", hzif.md_stall_cnt, 32'd0);
`endif
    @(negedge clk); #1 reset = 1'b0;
    nops(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
